// File: rtl/alumem_sequencer.sv
// -----------------------------------------------------------------------------
// alumem_sequencer
//
// Multi-cycle controller that owns the shared combinational ALU and the
// single-port synchronous data memory. It accepts one command at a time
// (ALU op, LOAD, STORE, read-modify-write), steps it through address
// generation, memory access and ALU evaluation using the one ALU, and then
// holds the response until the consumer takes it.
//
// Ports:
//   CLK, Reset             clock; synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake (ready only while idle)
//   cmd_op                 00 ALU, 01 LOAD, 10 STORE, 11 RMW
//   cmd_aluop              ALU opcode for ALU and RMW commands
//   cmd_a/cmd_b/cmd_imm    operand A or base address / operand B or store
//                          data / address offset
//   alu_a/alu_b/alu_op     operands and opcode driven to the shared ALU
//   alu_result/alu_ovf     combinational ALU result and overflow flag
//   mem_addr/mem_wdata     memory address and write data
//   mem_we/mem_re          memory write / read strobes (never both high)
//   mem_rdata              read data, valid MEM_LAT cycles after mem_re
//   rsp_valid/rsp_ready    response handshake
//   rsp_data/rsp_ovf/rsp_err  result word, ALU overflow, address fault
//   busy                   controller is not idle
// -----------------------------------------------------------------------------
module alumem_sequencer #(
    parameter int         W          = 16,
    parameter int         AW         = 8,
    parameter int         MEM_LAT    = 1,
    parameter logic [2:0] ALU_ADD_OP = 3'b010
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [2:0]    cmd_aluop,
    input  logic [W-1:0]  cmd_a,
    input  logic [W-1:0]  cmd_b,
    input  logic [W-1:0]  cmd_imm,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [2:0]    alu_op,
    input  logic [W-1:0]  alu_result,
    input  logic          alu_ovf,
    output logic [AW-1:0] mem_addr,
    output logic [W-1:0]  mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [W-1:0]  mem_rdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [W-1:0]  rsp_data,
    output logic          rsp_ovf,
    output logic          rsp_err,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_RD, S_WAIT, S_EXEC, S_WR, S_RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_ALU   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_RMW   = 2'b11
    } op_t;

    state_t        state_q, state_d;
    op_t           op_q;
    logic [2:0]    aluop_q;
    logic [W-1:0]  a_q, b_q, imm_q;
    logic [AW-1:0] addr_q;
    logic [W-1:0]  rdata_q;
    logic [1:0]    wait_cnt;     // MEM_LAT <= 4, so at most 3 is ever loaded
    logic          addr_fault;

    // An address is unusable if the add overflowed or any bit above the
    // memory's address range is set. Shifting by AW keeps this valid when
    // AW == W (the upper field is then empty).
    assign addr_fault = alu_ovf || ((alu_result >> AW) != '0);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking (=) here would create order-dependent
    // races between flops.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and all combinational outputs.
    // NOTE: every output gets a default before the case statement; a path
    // that left one unassigned would infer a latch.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = ALU_ADD_OP;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        rsp_valid = (state_q == S_RESP);
        busy      = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                cmd_ready = ~Reset;
                if (cmd_valid && cmd_ready) begin
                    state_d = (op_t'(cmd_op) == OP_ALU) ? S_EXEC : S_ADDR;
                end
            end
            S_ADDR: begin
                alu_a = a_q;
                alu_b = imm_q;
                if (addr_fault)              state_d = S_RESP;
                else if (op_q == OP_STORE)   state_d = S_WR;
                else                         state_d = S_RD;
            end
            S_RD: begin
                mem_re   = ~Reset;    // no memory access while in reset
                mem_addr = addr_q;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    state_d = (op_q == OP_LOAD) ? S_RESP : S_EXEC;
                end
            end
            S_EXEC: begin
                alu_a   = (op_q == OP_RMW) ? rdata_q : a_q;
                alu_b   = b_q;
                alu_op  = aluop_q;
                state_d = (op_q == OP_RMW) ? S_WR : S_RESP;
            end
            S_WR: begin
                mem_we    = ~Reset;
                mem_addr  = addr_q;
                // RMW writes back the ALU result already latched in rsp_data.
                mem_wdata = (op_q == OP_STORE) ? b_q : rsp_data;
                state_d   = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Command capture, address/read-data registers and the held response.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            op_q     <= OP_ALU;
            aluop_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            addr_q   <= '0;
            rdata_q  <= '0;
            wait_cnt <= '0;
            rsp_data <= '0;
            rsp_ovf  <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q     <= op_t'(cmd_op);
                        aluop_q  <= cmd_aluop;
                        a_q      <= cmd_a;
                        b_q      <= cmd_b;
                        imm_q    <= cmd_imm;
                        // Clear the previous response so flags never leak
                        // into a command that does not set them.
                        rsp_data <= '0;
                        rsp_ovf  <= 1'b0;
                        rsp_err  <= 1'b0;
                    end
                end
                S_ADDR: begin
                    addr_q <= alu_result[AW-1:0];
                    if (addr_fault) begin
                        rsp_err  <= 1'b1;
                        rsp_data <= '0;
                    end
                end
                S_RD: begin
                    wait_cnt <= 2'(MEM_LAT - 1);
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        rdata_q <= mem_rdata;
                        if (op_q == OP_LOAD) rsp_data <= mem_rdata;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                S_EXEC: begin
                    rsp_data <= alu_result;
                    rsp_ovf  <= alu_ovf;
                end
                S_WR: begin
                    if (op_q == OP_STORE) rsp_data <= b_q;
                end
                default: ;
            endcase
        end
    end

endmodule
